// File: rtl/crop_stream_arbiter_if.sv
// Stream bundle between the crop-norm bank, the crop arbiter and the
// downstream packer. The arbiter takes the master view: it accepts the
// per-crop input lanes and drives the merged output stream. The slave view
// is the surrounding environment (upstream channels plus downstream sink).
interface crop_stream_arbiter_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_CROPS = 4,
  parameter int IDX_W     = $clog2(NUM_CROPS)
);
  logic [NUM_CROPS-1:0] s_axis_tvalid;
  logic [NUM_CROPS-1:0] s_axis_tready;
  logic [DATA_W-1:0]    s_axis_tdata [NUM_CROPS];
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [DATA_W-1:0]    m_axis_tdata;
  logic                 m_axis_tlast;
  logic                 m_axis_tuser;
  logic [IDX_W-1:0]     m_axis_tid;

  modport master (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata,
           m_axis_tlast, m_axis_tuser, m_axis_tid
  );

  modport slave (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata,
           m_axis_tlast, m_axis_tuser, m_axis_tid
  );
endinterface

// File: rtl/crop_stream_arbiter.sv
// Merges NUM_CROPS crop channels into one stream, one whole crop at a time
// in ascending index order. A frame is armed from the runtime config while
// idle; the output is a single registered stage with TLAST/TUSER/TID.
// The interface instance must be built with the same DATA_W/NUM_CROPS.
module crop_stream_arbiter #(
  parameter int DATA_W          = 8,
  parameter int NUM_CROPS       = 4,
  parameter int MAX_CROP_PIXELS = 4096,
  parameter int IDX_W           = $clog2(NUM_CROPS),
  parameter int CNT_W           = $clog2(MAX_CROP_PIXELS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_enable,
  input  logic [NUM_CROPS-1:0] cfg_crop_mask,
  input  logic [CNT_W-1:0]     cfg_crop_pixels,
  crop_stream_arbiter_if.master axis,
  output logic [IDX_W-1:0]     crop_idx,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 cfg_err,
  output logic [15:0]          frame_count
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     crop_idx_reg, crop_idx_next;
  logic [CNT_W-1:0]     pix_cnt_reg, pix_cnt_next;
  logic                 first_flag_reg, first_flag_next;
  logic [NUM_CROPS-1:0] mask_reg, mask_next;
  logic [CNT_W-1:0]     pixels_reg, pixels_next;
  logic                 tvalid_reg, tvalid_next;
  logic [DATA_W-1:0]    tdata_reg, tdata_next;
  logic                 tlast_reg, tlast_next;
  logic                 tuser_reg, tuser_next;
  logic [IDX_W-1:0]     tid_reg, tid_next;
  logic                 frame_done_reg, frame_done_next;
  logic                 cfg_err_reg, cfg_err_next;
  logic [15:0]          frame_count_reg, frame_count_next;

  logic                 streaming;
  logic                 out_free;
  logic                 beat;
  logic                 last_pix;
  logic                 cfg_ok;
  logic [NUM_CROPS-1:0] s_ready;
  logic [NUM_CROPS-1:0] above_mask;
  logic [IDX_W-1:0]     first_idx;
  logic [IDX_W-1:0]     next_idx;
  logic                 next_found;

  assign streaming = (state_reg == STREAM);
  // The output stage can take a new pixel when empty or draining this cycle.
  assign out_free  = !tvalid_reg || axis.m_axis_tready;
  assign beat      = streaming && out_free && axis.s_axis_tvalid[crop_idx_reg];
  assign last_pix  = (pix_cnt_reg == pixels_reg - CNT_W'(1));
  assign cfg_ok    = (cfg_crop_mask != '0) && (cfg_crop_pixels != '0) &&
                     (cfg_crop_pixels <= CNT_W'(MAX_CROP_PIXELS));

  // Per-lane ready and "enabled crop above the current one" vectors.
  generate
    for (genvar gi = 0; gi < NUM_CROPS; gi++) begin : g_lane
      assign s_ready[gi]    = streaming && (crop_idx_reg == IDX_W'(gi)) && out_free;
      assign above_mask[gi] = mask_reg[gi] && (IDX_W'(gi) > crop_idx_reg);
    end
  endgenerate

  // Lowest-set-bit encoders: first crop of a new frame, next crop in this one.
  always_comb begin
    first_idx  = '0;
    next_idx   = '0;
    next_found = 1'b0;
    for (int i = NUM_CROPS - 1; i >= 0; i--) begin
      if (cfg_crop_mask[i]) first_idx = IDX_W'(i);
      if (above_mask[i]) begin
        next_idx   = IDX_W'(i);
        next_found = 1'b1;
      end
    end
  end

  // Next-state, counters and output-stage load decisions.
  always_comb begin
    state_next       = state_reg;
    crop_idx_next    = crop_idx_reg;
    pix_cnt_next     = pix_cnt_reg;
    first_flag_next  = first_flag_reg;
    mask_next        = mask_reg;
    pixels_next      = pixels_reg;
    tvalid_next      = tvalid_reg;
    tdata_next       = tdata_reg;
    tlast_next       = tlast_reg;
    tuser_next       = tuser_reg;
    tid_next         = tid_reg;
    frame_done_next  = 1'b0;
    cfg_err_next     = 1'b0;
    frame_count_next = frame_count_reg;

    case (state_reg)
      IDLE: begin
        if (cfg_enable) begin
          if (cfg_ok) begin
            mask_next       = cfg_crop_mask;
            pixels_next     = cfg_crop_pixels;
            crop_idx_next   = first_idx;
            pix_cnt_next    = '0;
            first_flag_next = 1'b1;
            state_next      = STREAM;
          end else begin
            cfg_err_next = 1'b1;
          end
        end
      end
      STREAM: begin
        if (beat) begin
          first_flag_next = 1'b0;
          if (last_pix) begin
            pix_cnt_next = '0;
            if (next_found) begin
              crop_idx_next = next_idx;
            end else begin
              state_next       = IDLE;
              frame_done_next  = 1'b1;
              frame_count_next = frame_count_reg + 16'd1;
            end
          end else begin
            pix_cnt_next = pix_cnt_reg + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A drain and a new beat in the same cycle simply reload the register.
    if (beat) begin
      tvalid_next = 1'b1;
      tdata_next  = axis.s_axis_tdata[crop_idx_reg];
      tid_next    = crop_idx_reg;
      tuser_next  = first_flag_reg;
      tlast_next  = last_pix;
    end else if (axis.m_axis_tready) begin
      tvalid_next = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      crop_idx_reg    <= '0;
      pix_cnt_reg     <= '0;
      first_flag_reg  <= 1'b0;
      mask_reg        <= '0;
      pixels_reg      <= '0;
      tvalid_reg      <= 1'b0;
      tdata_reg       <= '0;
      tlast_reg       <= 1'b0;
      tuser_reg       <= 1'b0;
      tid_reg         <= '0;
      frame_done_reg  <= 1'b0;
      cfg_err_reg     <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      crop_idx_reg    <= crop_idx_next;
      pix_cnt_reg     <= pix_cnt_next;
      first_flag_reg  <= first_flag_next;
      mask_reg        <= mask_next;
      pixels_reg      <= pixels_next;
      tvalid_reg      <= tvalid_next;
      tdata_reg       <= tdata_next;
      tlast_reg       <= tlast_next;
      tuser_reg       <= tuser_next;
      tid_reg         <= tid_next;
      frame_done_reg  <= frame_done_next;
      cfg_err_reg     <= cfg_err_next;
      frame_count_reg <= frame_count_next;
    end
  end

  assign axis.s_axis_tready = s_ready;
  assign axis.m_axis_tvalid = tvalid_reg;
  assign axis.m_axis_tdata  = tdata_reg;
  assign axis.m_axis_tlast  = tlast_reg;
  assign axis.m_axis_tuser  = tuser_reg;
  assign axis.m_axis_tid    = tid_reg;
  assign crop_idx           = crop_idx_reg;
  assign busy               = streaming;
  assign frame_done         = frame_done_reg;
  assign cfg_err            = cfg_err_reg;
  assign frame_count        = frame_count_reg;

endmodule

// File: tb/tb_crop_stream_arbiter.sv
// Bench for crop_stream_arbiter: directed frames, a frame-level reference
// model (expected output beats, expected input channel order, frame ends)
// and one negedge compare process.
module tb_crop_stream_arbiter;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int MAXP = 4096;
  localparam int CW = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [NC-1:0] cfg_crop_mask = '0;
  logic [CW-1:0] cfg_crop_pixels = '0;
  logic [1:0]    crop_idx;
  logic          busy, frame_done, cfg_err;
  logic [15:0]   frame_count;

  crop_stream_arbiter_if #(.DATA_W(DW), .NUM_CROPS(NC)) bus ();

  crop_stream_arbiter #(.DATA_W(DW), .NUM_CROPS(NC), .MAX_CROP_PIXELS(MAXP)) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_enable      (cfg_enable),
    .cfg_crop_mask   (cfg_crop_mask),
    .cfg_crop_pixels (cfg_crop_pixels),
    .axis            (bus),
    .crop_idx        (crop_idx),
    .busy            (busy),
    .frame_done      (frame_done),
    .cfg_err         (cfg_err),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int src_cnt [NC];
  int mdl_cnt [NC];
  int out_q [$];
  int in_ch_q [$];
  int tot_q [$];
  int mask_q [$];
  int in_cnt = 0;
  bit done_pending = 1'b0;
  int model_frames = 0;
  int cyc = 0;
  int log_val [64];
  int log_cyc [64];
  int log_n = 0;
  bit rand_valid = 1'b0;
  bit rand_ready = 1'b0;
  bit stall_prev = 1'b0;
  int snap = 0;

  // Upstream pixel value: k-th pixel ever taken from channel c.
  function automatic int pix_val(int c, int k);
    return (c * 64 + k * 3 + 1) & 255;
  endfunction

  function automatic int pack(int d, int t, int u, int l);
    return (d << 4) | (t << 2) | (u << 1) | l;
  endfunction

  function automatic int cur_mask();
    return (mask_q.size() != 0) ? mask_q[0] : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Source/sink driver: upstream valid and data, downstream ready.
  always @(posedge clk) begin
    #1;
    bus.s_axis_tvalid = rand_valid ? 4'($urandom) : 4'hF;
    bus.m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < NC; c++) bus.s_axis_tdata[c] = 8'(pix_val(c, src_cnt[c]));
  end

  // Compare process: handshakes seen here happen at the following posedge.
  always @(negedge clk) begin
    int sr;
    int act;
    cyc++;
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      sr = int'(bus.s_axis_tready);
      if (sr != 0) begin
        chk("tready_onehot", $countones(bus.s_axis_tready), 1);
        chk("tready_in_mask", sr & ~cur_mask(), 0);
      end
      if (!busy) chk("tready_idle", sr, 0);
      act = pack(int'(bus.m_axis_tdata), int'(bus.m_axis_tid),
                 int'(bus.m_axis_tuser), int'(bus.m_axis_tlast));
      if (stall_prev) begin
        chk("stall_valid", int'(bus.m_axis_tvalid), 1);
        chk("stall_hold", act, snap);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (out_q.size() == 0) begin
          chk("extra_out_beat", 1, 0);
        end else begin
          chk("out_beat", act, out_q[0]);
          void'(out_q.pop_front());
        end
        $display("[TB] out tid=%0d data=%0d tuser=%0d tlast=%0d", bus.m_axis_tid,
                 bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast);
        if (log_n < 64) begin
          log_val[log_n] = act;
          log_cyc[log_n] = cyc;
          log_n++;
        end
      end
      stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
      snap = act;
      chk("frame_done", int'(frame_done), int'(done_pending));
      if (done_pending) chk("frame_count", int'(frame_count), model_frames);
      done_pending = 1'b0;
      for (int c = 0; c < NC; c++) begin
        if (bus.s_axis_tvalid[c] && bus.s_axis_tready[c]) begin
          src_cnt[c]++;
          if (in_ch_q.size() == 0) begin
            chk("extra_in_beat", 1, 0);
          end else begin
            chk("in_channel", c, in_ch_q[0]);
            void'(in_ch_q.pop_front());
            in_cnt++;
            if (in_cnt == tot_q[0]) begin
              void'(tot_q.pop_front());
              void'(mask_q.pop_front());
              in_cnt = 0;
              done_pending = 1'b1;
              model_frames++;
            end
          end
        end
      end
    end
  end

  // Arm a frame and queue what the model says it must produce.
  task automatic run_frame(input logic [NC-1:0] mask, input int pix);
    int first = 1;
    cfg_crop_mask   = mask;
    cfg_crop_pixels = CW'(pix);
    cfg_enable      = 1'b1;
    log_n = 0;
    for (int c = 0; c < NC; c++) begin
      if (mask[c]) begin
        for (int k = 0; k < pix; k++) begin
          out_q.push_back(pack(pix_val(c, mdl_cnt[c]), c, first, (k == pix - 1) ? 1 : 0));
          in_ch_q.push_back(c);
          first = 0;
          mdl_cnt[c]++;
        end
      end
    end
    tot_q.push_back($countones(mask) * pix);
    mask_q.push_back(int'(mask));
    tick();
    cfg_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 3000 && !(out_q.size() == 0 && tot_q.size() == 0 && !busy &&
                         !bus.m_axis_tvalid)) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n < 3000) ? 1 : 0, 1);
    tick();
  endtask

  task automatic check_reset_vals();
    chk("rst_tvalid", int'(bus.m_axis_tvalid), 0);
    chk("rst_tlast", int'(bus.m_axis_tlast), 0);
    chk("rst_tuser", int'(bus.m_axis_tuser), 0);
    chk("rst_tdata", int'(bus.m_axis_tdata), 0);
    chk("rst_tid", int'(bus.m_axis_tid), 0);
    chk("rst_tready", int'(bus.s_axis_tready), 0);
    chk("rst_crop_idx", int'(crop_idx), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    chk("rst_frame_count", int'(frame_count), 0);
  endtask

  task automatic bad_cfg(input logic [NC-1:0] mask, input int pix, input string name);
    cfg_crop_mask   = mask;
    cfg_crop_pixels = CW'(pix);
    cfg_enable      = 1'b1;
    tick();
    chk({name, "_err"}, int'(cfg_err), 1);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_tready"}, int'(bus.s_axis_tready), 0);
    cfg_enable = 1'b0;
    tick();
    chk({name, "_err_clear"}, int'(cfg_err), 0);
    chk({name, "_busy2"}, int'(busy), 0);
  endtask

  int exp_tid2 [6] = '{1, 1, 1, 3, 3, 3};

  initial begin
    for (int c = 0; c < NC; c++) begin
      src_cnt[c] = 0;
      mdl_cnt[c] = 0;
    end
    reset = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    reset = 1'b1;
    tick();

    // All four crops, four pixels each, no backpressure.
    run_frame(4'b1111, 4);
    wait_idle();
    chk("t1_count", log_n, 16);
    chk("t1_first", log_val[0], 18);      // data 1, tid 0, tuser 1, tlast 0
    chk("t1_last", log_val[15], 3245);    // data 202, tid 3, tuser 0, tlast 1
    chk("t1_tid4", (log_val[4] >> 2) & 3, 1);
    chk("t1_tlast3", log_val[3] & 1, 1);
    chk("t1_tlast7", log_val[7] & 1, 1);
    chk("t1_tlast11", log_val[11] & 1, 1);
    chk("t1_tuser1", (log_val[1] >> 1) & 1, 0);
    chk("t1_frame_count", int'(frame_count), 1);

    // Sparse mask: only crops 1 and 3, seamless switch between them.
    run_frame(4'b1010, 3);
    wait_idle();
    chk("t2_count", log_n, 6);
    for (int i = 0; i < 6; i++) chk("t2_tid", (log_val[i] >> 2) & 3, exp_tid2[i]);
    chk("t2_no_bubble", log_cyc[3] - log_cyc[2], 1);

    // One pixel per crop: every beat is a crop end.
    run_frame(4'b1001, 1);
    wait_idle();
    chk("t3_count", log_n, 2);
    chk("t3_last0", log_val[0] & 3, 3);
    chk("t3_last1", log_val[1] & 3, 1);
    run_frame(4'b0100, 1);
    wait_idle();
    chk("t3_single", log_val[0] & 15, 11); // tid 2, tuser 1, tlast 1

    // Random backpressure and upstream valid gaps.
    rand_valid = 1'b1;
    rand_ready = 1'b1;
    run_frame(4'b1111, 20);
    wait_idle();
    run_frame(4'b1011, 20);
    wait_idle();
    run_frame(4'b0101, 20);
    wait_idle();
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    tick();

    // Config change mid-frame only affects the next frame.
    run_frame(4'b0011, 5);
    repeat (3) tick();
    cfg_crop_mask = 4'b1100;
    wait_idle();
    chk("t5_count", log_n, 10);
    chk("t5_last_tid", (log_val[9] >> 2) & 3, 1);
    run_frame(4'b1100, 5);
    wait_idle();
    chk("t5_next_tid", (log_val[0] >> 2) & 3, 2);

    // Rejected frame starts.
    bad_cfg(4'b0000, 4, "mask0");
    bad_cfg(4'b1111, 0, "pix0");
    bad_cfg(4'b1111, MAXP + 1, "pixmax");

    // Reset in the middle of a crop.
    run_frame(4'b1111, 20);
    begin
      int n = 0;
      while (in_cnt < 7 && n < 200) begin
        tick();
        n++;
      end
      chk("t7_reach_pix7", in_cnt, 7);
    end
    reset = 1'b0;
    tick();
    check_reset_vals();
    out_q.delete();
    in_ch_q.delete();
    tot_q.delete();
    mask_q.delete();
    in_cnt = 0;
    done_pending = 1'b0;
    model_frames = 0;
    stall_prev = 1'b0;
    for (int c = 0; c < NC; c++) mdl_cnt[c] = src_cnt[c];
    reset = 1'b1;
    tick();
    run_frame(4'b0110, 3);
    wait_idle();
    chk("t7_first_tid", (log_val[0] >> 2) & 3, 1);
    chk("t7_first_tuser", (log_val[0] >> 1) & 1, 1);
    chk("t7_frame_count", int'(frame_count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
